// File: rtl/cpu_pkg.sv
// Shared types for the parametrised accumulator CPU: opcodes, FSM states and
// the register write-data select used by the top level.
package cpu_pkg;

   typedef enum logic [3:0] {
      OP_ADD   = 4'h0,
      OP_SUB   = 4'h1,
      OP_INC   = 4'h2,
      OP_DEC   = 4'h3,
      OP_ADC   = 4'h4,
      OP_NEG   = 4'h5,
      OP_LDA   = 4'h6,
      OP_LDB   = 4'h7,
      OP_STI   = 4'h8,
      OP_STC   = 4'h9,
      OP_LDC   = 4'hA,
      OP_OUTC  = 4'hB,
      OP_OUTM  = 4'hC,
      OP_MOVAC = 4'hD,
      OP_MOVBC = 4'hE,
      OP_HALT  = 4'hF
   } opcode_t;

   typedef enum logic [2:0] {
      ST_FETCH,
      ST_EXEC,
      ST_OPND,
      ST_MEM_RD,
      ST_OUT_WAIT,
      ST_HALT
   } state_t;

   typedef enum logic [1:0] {
      SEL_IN,
      SEL_C,
      SEL_ALU,
      SEL_MEM
   } wsel_t;

endpackage

// File: rtl/param_acc_cpu_if.sv
// Input instruction/operand stream and output result stream, both valid/ready.
interface param_acc_cpu_if #(parameter int DATA_W = 8);

   logic [DATA_W-1:0] in_data;
   logic              in_valid;
   logic              in_ready;
   logic [DATA_W-1:0] out_data;
   logic              out_valid;
   logic              out_ready;

   modport master (
      output in_data, in_valid, out_ready,
      input  in_ready, out_data, out_valid
   );

   modport slave (
      input  in_data, in_valid, out_ready,
      output in_ready, out_data, out_valid
   );

endinterface

// File: rtl/param_sp_ram.sv
// Single-port RAM, synchronous write and read; a read during a write returns
// the old contents.
module param_sp_ram #(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 4
) (
   input  logic              clk,
   input  logic              we,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] wdata,
   output logic [DATA_W-1:0] rdata
);

   logic [DATA_W-1:0] mem [2**ADDR_W];

   always_ff @(posedge clk) begin
      if (we) begin
         mem[addr] <= wdata;
      end
      rdata <= mem[addr];
   end

endmodule

// File: rtl/param_acc_cpu.sv
// Parametrised three-register accumulator CPU with streamed instructions and
// results. Define CPU_FLAGS_EN to add carry/zero status registers and ports.
module param_acc_cpu
   import cpu_pkg::*;
#(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 4,
   parameter int OP_LSB = DATA_W - 4
) (
   input  logic           clk,
   input  logic           reset,
   param_acc_cpu_if.slave bus,
   output logic           halted
`ifdef CPU_FLAGS_EN
   ,
   output logic           flag_c,
   output logic           flag_z
`endif
);

`ifdef CPU_FLAGS_EN
   localparam int ALU_W = DATA_W + 1;
`else
   localparam int ALU_W = DATA_W;
`endif

   state_t            state_q;
   logic [DATA_W-1:0] instr_q, regA_q, regB_q, regC_q, outData_q;
   logic              outValid_q, halted_q;
`ifdef CPU_FLAGS_EN
   logic              flagC_q, flagZ_q;
`endif

   opcode_t           op;
   logic [ADDR_W-1:0] addr;
   logic              inReady, inFire, ramWe;
   logic [DATA_W-1:0] ramRdata, wdata_d;
   wsel_t             wsel;
   logic [ALU_W-1:0]  aExt, bExt, alu_d;

   assign op      = opcode_t'(instr_q[OP_LSB+3:OP_LSB]);
   assign addr    = instr_q[ADDR_W-1:0];
   assign inReady = ~reset && (state_q == ST_FETCH || state_q == ST_OPND);
   assign inFire  = inReady && bus.in_valid;
   assign ramWe   = (state_q == ST_OPND && op == OP_STI && inFire) ||
                    (state_q == ST_EXEC && op == OP_STC);

   assign bus.in_ready  = inReady;
   assign bus.out_data  = outData_q;
   assign bus.out_valid = outValid_q;
   assign halted        = halted_q;
`ifdef CPU_FLAGS_EN
   assign flag_c = flagC_q;
   assign flag_z = flagZ_q;
`endif

   // The extra top bit (when present) carries out of adds and borrows out of
   // subtracts, since both operands are zero-extended.
   assign aExt = ALU_W'(regA_q);
   assign bExt = ALU_W'(regB_q);

   always_comb begin
      alu_d = '0;
      case (op)
         OP_ADD:  alu_d = aExt + bExt;
         OP_SUB:  alu_d = aExt - bExt;
         OP_INC:  alu_d = aExt + ALU_W'(1);
         OP_DEC:  alu_d = aExt - ALU_W'(1);
         OP_ADC:  alu_d = aExt + bExt + ALU_W'(1);
         OP_NEG:  alu_d = '0 - aExt;
         default: alu_d = '0;
      endcase
   end

   // One shared data path feeds A/B/C, out_data and the RAM write port.
   always_comb begin
      wsel = SEL_ALU;
      if (state_q == ST_OPND) begin
         wsel = SEL_IN;
      end else if (state_q == ST_MEM_RD) begin
         wsel = SEL_MEM;
      end else if (op inside {OP_STC, OP_OUTC, OP_MOVAC, OP_MOVBC}) begin
         wsel = SEL_C;
      end
      wdata_d = '0;
      case (wsel)
         SEL_IN:  wdata_d = bus.in_data;
         SEL_C:   wdata_d = regC_q;
         SEL_ALU: wdata_d = alu_d[DATA_W-1:0];
         SEL_MEM: wdata_d = ramRdata;
      endcase
   end

   param_sp_ram #(
      .DATA_W(DATA_W),
      .ADDR_W(ADDR_W)
   ) u_ram (
      .clk  (clk),
      .we   (ramWe),
      .addr (addr),
      .wdata(wdata_d),
      .rdata(ramRdata)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= ST_FETCH;
         instr_q    <= '0;
         regA_q     <= '0;
         regB_q     <= '0;
         regC_q     <= '0;
         outData_q  <= '0;
         outValid_q <= 1'b0;
         halted_q   <= 1'b0;
`ifdef CPU_FLAGS_EN
         flagC_q    <= 1'b0;
         flagZ_q    <= 1'b0;
`endif
      end else begin
         case (state_q)
            ST_FETCH: begin
               if (inFire) begin
                  instr_q <= bus.in_data;
                  state_q <= ST_EXEC;
               end
            end
            ST_EXEC: begin
               case (op)
                  OP_ADD, OP_SUB, OP_INC, OP_DEC, OP_ADC, OP_NEG: begin
                     regC_q  <= wdata_d;
`ifdef CPU_FLAGS_EN
                     flagC_q <= alu_d[DATA_W];
                     flagZ_q <= (alu_d[DATA_W-1:0] == '0);
`endif
                     state_q <= ST_FETCH;
                  end
                  OP_LDA, OP_LDB, OP_STI: state_q <= ST_OPND;
                  OP_STC:                 state_q <= ST_FETCH;
                  OP_LDC, OP_OUTM:        state_q <= ST_MEM_RD;
                  OP_OUTC: begin
                     outData_q  <= wdata_d;
                     outValid_q <= 1'b1;
                     state_q    <= ST_OUT_WAIT;
                  end
                  OP_MOVAC: begin
                     regA_q  <= wdata_d;
                     state_q <= ST_FETCH;
                  end
                  OP_MOVBC: begin
                     regB_q  <= wdata_d;
                     state_q <= ST_FETCH;
                  end
                  OP_HALT: begin
                     halted_q <= 1'b1;
                     state_q  <= ST_HALT;
                  end
               endcase
            end
            ST_OPND: begin
               if (inFire) begin
                  if (op == OP_LDA) regA_q <= wdata_d;
                  if (op == OP_LDB) regB_q <= wdata_d;
                  state_q <= ST_FETCH;
               end
            end
            ST_MEM_RD: begin
               if (op == OP_OUTM) begin
                  outData_q  <= wdata_d;
                  outValid_q <= 1'b1;
                  state_q    <= ST_OUT_WAIT;
               end else begin
                  regC_q  <= wdata_d;
                  state_q <= ST_FETCH;
               end
            end
            ST_OUT_WAIT: begin
               if (bus.out_ready) begin
                  outValid_q <= 1'b0;
                  state_q    <= ST_FETCH;
               end
            end
            ST_HALT: state_q <= ST_HALT;
            default: state_q <= ST_FETCH;
         endcase
      end
   end

endmodule

// File: tb/tb_param_acc_cpu.sv
// Self-checking bench for param_acc_cpu: directed scenarios followed by a
// random instruction stream compared against a behavioural CPU model.
module tb_param_acc_cpu;

   logic clk;
   logic reset;
   logic halted;
`ifdef CPU_FLAGS_EN
   logic flagC, flagZ;
`endif

   param_acc_cpu_if #(.DATA_W(8)) bus ();

   param_acc_cpu #(
      .DATA_W(8),
      .ADDR_W(4)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus),
      .halted(halted)
`ifdef CPU_FLAGS_EN
      ,
      .flag_c(flagC),
      .flag_z(flagZ)
`endif
   );

   int checkCount = 0;
   int passCount  = 0;

   // Behavioural model state
   int   mA, mB, mC;
   bit   mCarry, mZero;
   int   mMem [16];
   bit   mWritten [16];

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #500000;
      $display("[TB] FAIL watchdog expired checks=%0d", checkCount);
      $fatal(1, "[TB] watchdog");
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checkCount++;
      if (observed === expected) begin
         passCount++;
      end else begin
         $display("[TB] FAIL %s observed=0x%0h expected=0x%0h at %0t", tag, observed, expected, $time);
      end
   endtask

   // Present one word on the input stream; returns at the negedge after it is taken.
   task automatic applyStimulus(input logic [7:0] w);
      int n = 0;
      repeat ($urandom_range(1, 2)) @(negedge clk);
      while (!bus.in_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (!bus.in_ready) begin
         checkOutput("in_ready_wait", bus.in_ready, 1);
         return;
      end
      bus.in_valid = 1'b1;
      bus.in_data  = w;
      @(negedge clk);
      bus.in_valid = 1'b0;
      bus.in_data  = $urandom_range(0, 255);
   endtask

   task automatic takeOutput(input logic [7:0] exp, input int stall);
      int n = 0;
      while (!bus.out_valid && n < 10) begin
         @(negedge clk);
         n++;
      end
      checkOutput("out_valid_rise", bus.out_valid, 1);
      if (!bus.out_valid) return;
      checkOutput("out_data", bus.out_data, exp);
      for (int i = 0; i < stall; i++) begin
         @(negedge clk);
         checkOutput("hold_valid", bus.out_valid, 1);
         checkOutput("hold_data", bus.out_data, exp);
         checkOutput("hold_in_ready", bus.in_ready, 0);
      end
      bus.out_ready = 1'b1;
      @(negedge clk);
      bus.out_ready = 1'b0;
      checkOutput("valid_drop", bus.out_valid, 0);
      checkOutput("fetch_in_ready", bus.in_ready, 1);
   endtask

   task automatic modelReset();
      mA = 0; mB = 0; mC = 0;
      mCarry = 1'b0; mZero = 1'b0;
   endtask

   // Reset asserted between clock edges; outputs must clear before the next edge.
   task automatic resetPulse();
      @(negedge clk);
      #2 reset = 1'b1;
      #1;
      checkOutput("rst_out_valid", bus.out_valid, 0);
      checkOutput("rst_out_data", bus.out_data, 0);
      checkOutput("rst_halted", halted, 0);
      checkOutput("rst_in_ready", bus.in_ready, 0);
      @(negedge clk);
      reset = 1'b0;
      #1;
      checkOutput("post_rst_in_ready", bus.in_ready, 1);
      modelReset();
   endtask

   // Issue one instruction, update the model and check what becomes visible.
   task automatic execute(input int op, input int addr, input int operand, input int stall);
      int r;
      applyStimulus(8'((op << 4) | addr));
      case (op)
         0, 1, 2, 3, 4, 5: begin
            case (op)
               0:       r = mA + mB;
               1:       r = mA - mB;
               2:       r = mA + 1;
               3:       r = mA - 1;
               4:       r = mA + mB + 1;
               default: r = -mA;
            endcase
            mCarry = (r < 0) || (r > 255);
            mC     = r & 255;
            mZero  = (mC == 0);
            @(negedge clk);
`ifdef CPU_FLAGS_EN
            checkOutput("flag_c", flagC, mCarry);
            checkOutput("flag_z", flagZ, mZero);
`endif
         end
         6: begin applyStimulus(8'(operand)); mA = operand; end
         7: begin applyStimulus(8'(operand)); mB = operand; end
         8: begin
            applyStimulus(8'(operand));
            mMem[addr] = operand;
            mWritten[addr] = 1'b1;
         end
         9: begin mMem[addr] = mC; mWritten[addr] = 1'b1; end
         10: mC = mMem[addr];
         11: takeOutput(8'(mC), stall);
         12: takeOutput(8'(mMem[addr]), stall);
         13: mA = mC;
         14: mB = mC;
         default: ;
      endcase
   endtask

   initial begin
      int op, addr;
      bus.in_valid  = 1'b0;
      bus.in_data   = '0;
      bus.out_ready = 1'b0;
      reset         = 1'b1;
      modelReset();
      for (int i = 0; i < 16; i++) begin
         mMem[i] = 0;
         mWritten[i] = 1'b0;
      end
      repeat (2) @(negedge clk);
      checkOutput("reset_out_valid", bus.out_valid, 0);
      checkOutput("reset_out_data", bus.out_data, 0);
      checkOutput("reset_halted", halted, 0);
      checkOutput("reset_in_ready", bus.in_ready, 0);
`ifdef CPU_FLAGS_EN
      checkOutput("reset_flag_c", flagC, 0);
      checkOutput("reset_flag_z", flagZ, 0);
`endif
      reset = 1'b0;
      #1;
      checkOutput("fetch_ready", bus.in_ready, 1);

      // A=5, B=3, ADD, OUTC
      execute(6, 0, 8'h05, 0);
      execute(7, 0, 8'h03, 0);
      execute(0, 0, 0, 0);
      execute(11, 0, 0, 0);

      // SUB borrow, INC wrap to zero
      execute(6, 0, 8'h03, 0);
      execute(7, 0, 8'h05, 0);
      execute(1, 0, 0, 0);
      execute(11, 0, 0, 1);
      execute(6, 0, 8'hFF, 0);
      execute(2, 0, 0, 0);
      execute(11, 0, 0, 0);

      // Memory path: STI/OUTM, STC/LDC/OUTC
      execute(8, 15, 8'hA5, 0);
      execute(12, 15, 0, 0);
      execute(6, 0, 8'h5A, 0);
      execute(7, 0, 8'h00, 0);
      execute(0, 0, 0, 0);
      execute(9, 3, 0, 0);
      execute(2, 0, 0, 0);
      execute(10, 3, 0, 0);
      execute(11, 0, 0, 0);

      // Output held under backpressure
      execute(11, 0, 0, 5);

      // HALT ignores input until reset
      applyStimulus(8'hF0);
      @(negedge clk);
      for (int i = 0; i < 20; i++) begin
         bus.in_valid = 1'($urandom_range(0, 1));
         bus.in_data  = 8'($urandom_range(0, 255));
         @(negedge clk);
         checkOutput("halt_halted", halted, 1);
         checkOutput("halt_in_ready", bus.in_ready, 0);
         checkOutput("halt_out_valid", bus.out_valid, 0);
      end
      bus.in_valid = 1'b0;
      resetPulse();

      // Reset while an output is pending, then C reads back as zero
      execute(6, 0, 8'h77, 0);
      execute(13, 0, 0, 0);
      execute(2, 0, 0, 0);
      applyStimulus(8'hB0);
      @(negedge clk);
      checkOutput("pending_valid", bus.out_valid, 1);
      resetPulse();
      execute(11, 0, 0, 0);

      // Random instruction stream against the model
      for (int i = 0; i < 300; i++) begin
         op   = $urandom_range(0, 14);
         addr = $urandom_range(0, 15);
         if ((op == 10 || op == 12) && !mWritten[addr]) op = 9;
         execute(op, addr, $urandom_range(0, 255), $urandom_range(0, 3));
         if (i % 8 == 7) execute(11, 0, 0, $urandom_range(0, 2));
      end

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule

// File: doc/param_acc_cpu.md
Name: param_acc_cpu

Overview:
Parametrised successor of the 8-bit three-register accumulator CPU.
- Data width and RAM depth are generic.
- Instruction and operand words arrive on one input stream with valid/ready.
- Results leave on an output stream with valid/ready and backpressure.
- Control is a multi-cycle FSM with explicit RAM-latency and output-hold states. Adds carry/zero status and a HALT instruction.

Parameters:
DATA_W, 8, width of registers A/B/C, RAM words and in/out data.
ADDR_W, 4, RAM address width; depth = 2**ADDR_W. Legal only if DATA_W >= 4+ADDR_W.
OP_LSB, DATA_W-4, bit position of the 4-bit opcode inside an instruction word.

Ports:
clk  in  1  clock, rising edge.
reset  in  1  asynchronous, active-high; clears all state.
in_data  in  DATA_W  instruction word, or operand word when one is expected.
in_valid  in  1  in_data valid.
in_ready  out  1  block accepts in_data this cycle.
out_data  out  DATA_W  output value.
out_valid  out  1  out_data valid; held until accepted.
out_ready  in  1  consumer accepts out_data.
halted  out  1  HALT executed.

Behaviour:
Reset values:
- state=FETCH; A=B=C=0; flags 0.
- out_data=0, out_valid=0, halted=0, in_ready=0 while reset is high.
- RAM contents are not reset.

Instruction word:
- opcode = in_data[OP_LSB+3:OP_LSB]; addr = in_data[ADDR_W-1:0]; other bits ignored.

States: FETCH, EXEC, OPND, MEM_RD, OUT_WAIT, HALT.
- FETCH: in_ready=1. On in_valid&in_ready, latch instr and go to EXEC.
- EXEC, opcodes 0-5 (ALU, write C, then FETCH):
  - 0: C=A+B
  - 1: C=A-B
  - 2: C=A+1
  - 3: C=A-1
  - 4: C=A+B+1
  - 5: C=-A
- EXEC, 6/7/8 (LDA/LDB/STI): go to OPND.
  - OPND: in_ready=1. On handshake: A or B <= in_data, or RAM[addr] <= in_data. Then FETCH.
- EXEC, 9 (STC): RAM[addr] <= C, then FETCH.
- EXEC, A/C (LDC/OUTM): RAM read issued in EXEC, data valid in MEM_RD one cycle later.
  - LDC: C <= rdata, then FETCH.
  - OUTM: out_data <= rdata, then OUT_WAIT.
- EXEC, B (OUTC): out_data <= C, then OUT_WAIT.
- EXEC, D/E (MOVAC/MOVBC): A=C or B=C, then FETCH.
- EXEC, F: go to HALT.
- OUT_WAIT: out_valid=1, out_data stable. Leave to FETCH on out_ready.
  - out_valid drops the cycle after the handshake.
  - in_ready=0 throughout OUT_WAIT.
- HALT: halted=1, in_ready=0, out_valid=0. Exit only by reset.

in_ready is 0 in EXEC, MEM_RD, OUT_WAIT and HALT.

Latency (cycles from accepted instruction to return to FETCH):
- ALU, move, STC: 2.
- Load and STI: 2 + operand wait.
- LDC: 3.
- Outputs: 3 + backpressure.

Arithmetic:
- Computed at DATA_W+1 bits and truncated to DATA_W into C; wrap is silent.
- carry = bit DATA_W of the extended result (borrow for SUB/DEC/NEG).
- zero = (truncated result == 0).
- Flags update only on opcodes 0-5.

RAM addressing: addr spans the full depth, so there is no out-of-range case. Reading a never-written location returns an undefined value.

Reset mid-operation: async assertion returns FETCH, clears registers, drops out_valid and in_ready immediately. A partially completed STI or STC is discarded if reset precedes the clock edge.

Optional Feature:
CPU_FLAGS_EN.
- Defined: adds output ports flag_c and flag_z (1 bit each, reset 0), driven by the carry/zero registers.
- Also adds opcode-5 variant behaviour: none. Flags are status only.
- Undefined: no flag ports, no flag registers; ALU computes at DATA_W bits.

Decomposition:
Shared package cpu_pkg holds:
- the 4-bit opcode enumeration (OP_ADD..OP_HALT);
- the FSM state enumeration;
- write-data select constants (SEL_IN, SEL_C, SEL_ALU, SEL_MEM).

One sub-module, param_sp_ram:
- parameters DATA_W, ADDR_W; ports clk, we, addr, wdata, rdata;
- synchronous write, synchronous read, read-during-write returns old data.

ALU stays combinational inside the top level.

Test Plan:
1. in stream 0x60, 0x05, 0x70, 0x03, 0x00, 0xB0 -> one out handshake with out_data=0x08; flag_z=0, flag_c=0.
2. A=0x03, B=0x05, opcode 0x10 then 0xB0 -> out_data=0xFE, flag_c=1. A=0xFF, opcode 0x20 -> C=0x00, flag_z=1, flag_c=1.
3. STI 0x8F, 0xA5; OUTM 0xCF -> out_data=0xA5. STC 0x93 with C=0x5A; LDC 0xA3; OUTC -> out_data=0x5A.
4. OUTC with out_ready=0 for 5 cycles -> out_valid=1 and out_data constant for 5 cycles, in_ready=0. Handshake on the 6th cycle, FETCH on the next.
5. opcode 0xF0 -> halted=1, in_ready=0 for 20 cycles regardless of in_valid. Reset pulse -> halted=0, in_ready=1 in FETCH.
6. reset asserted between clock edges during OUT_WAIT -> out_valid=0 and out_data=0 before the next edge. Subsequent OUTC returns 0x00.
